// File: rtl/memory_controller.sv
// Single-port word memory with a boot sequencer that fills the RAM after reset.
// Define BOOT_IMAGE_EN to fill from an internal boot ROM image instead of zeros.

module memory_controller_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] ram [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Read-first: the array is sampled before this edge's write lands.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = ram[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

module memory_controller #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int BYPASS_BOOT = 0,
    parameter     INIT_FILE   = "boot.mem"
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  boot_done,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);
    typedef enum logic [0:0] {
        ST_BOOT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t                RESET_STATE = (BYPASS_BOOT != 0) ? ST_READY : ST_BOOT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = {ADDR_WIDTH{1'b1}};

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic                  boot_done_q;
    logic                  boot_done_d;
    logic                  ram_we_s;
    logic                  ram_re_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic [DATA_WIDTH-1:0] fill_s;

`ifdef BOOT_IMAGE_EN
    logic [DATA_WIDTH-1:0] rom [0:(2**ADDR_WIDTH)-1];

    // Boot ROM image contents.
    initial begin
        for (int i = 0; i < (2**ADDR_WIDTH); i++) begin
            rom[i] = {DATA_WIDTH{1'b0}};
        end
    end

    assign fill_s = rom[ptr_q];
`else
    assign fill_s = {DATA_WIDTH{1'b0}};
`endif

    // Next-state and RAM port steering; host requests only pass once boot_done is already set.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        boot_done_d = boot_done_q;
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_addr_s  = addr;
        ram_wdata_s = write_data;
        case (state_q)
            ST_BOOT: begin
                ram_we_s    = ~rst;
                ram_addr_s  = ptr_q;
                ram_wdata_s = fill_s;
                ptr_d       = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (ptr_q == LAST_ADDR) begin
                    state_d     = ST_READY;
                    boot_done_d = 1'b1;
                end else begin
                    state_d     = ST_BOOT;
                    boot_done_d = 1'b0;
                end
            end
            ST_READY: begin
                boot_done_d = 1'b1;
                if (boot_done_q) begin
                    ram_we_s = write_enable & ~rst;
                    ram_re_s = read_enable & ~rst;
                end else begin
                    ram_we_s = 1'b0;
                    ram_re_s = 1'b0;
                end
            end
            default: begin
                state_d     = RESET_STATE;
                boot_done_d = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            ptr_q       <= {ADDR_WIDTH{1'b0}};
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            boot_done_q <= boot_done_d;
        end
    end

    memory_controller_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (read_data)
    );

    assign boot_done = boot_done_q;
endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench: a booted DUT checked against an array model, plus a BYPASS_BOOT instance.

module tb_memory_controller;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          bd;

    logic          b_rst;
    logic          b_re;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rd;
    logic          b_bd;
    logic          b_we = 1'b0;
    logic [DW-1:0] b_wd = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int edges    = 0;
    bit mon_en   = 1'b0;

    logic [DW-1:0] mem_model [DEPTH];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS_BOOT(0)) dut (
        .clk(clk), .rst(rst), .boot_done(bd), .write_enable(we), .read_enable(re),
        .addr(addr), .write_data(wd), .read_data(rd)
    );

    memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS_BOOT(1)) dut_byp (
        .clk(clk), .rst(b_rst), .boot_done(b_bd), .write_enable(b_we), .read_enable(b_re),
        .addr(b_addr), .write_data(b_wd), .read_data(b_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides what the edge should do.
    task automatic step(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = w; re = r; addr = a; wd = d;
        if (!rst && edges >= DEPTH) begin
            if (r) exp_q.push_back(mem_model[a]);
            if (w) mem_model[a] = d;
        end
        @(posedge clk); #1;
        if (rst) begin
            edges = 0;
        end else begin
            edges++;
            if (edges == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
            end
        end
    endtask

    // Monitor: pops an expectation for every serviced read, checks hold otherwise.
    bit            fire_prev = 1'b0;
    bit            rst_prev  = 1'b1;
    logic [DW-1:0] last_exp  = 8'h00;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_prev) begin
                last_exp = 8'h00;
            end else if (fire_prev) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) last_exp = exp_q.pop_front();
            end
            check("read_data", 32'(rd), 32'(last_exp));
            check("boot_done", 32'(bd), 32'(edges >= DEPTH));
            fire_prev = bd && re && !rst;
            rst_prev  = rst;
        end
    end

    int cnt;
    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wd = '0;
        b_rst = 1'b1; b_re = 1'b0; b_addr = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("byp_reset_bd", 32'(b_bd), 32'd0);
        check("byp_reset_rd", 32'(b_rd), 32'd0);

        // Bypass instance: preload, read after two edges, reset keeps contents.
        b_rst = 1'b0;
        dut_byp.ram.ram[0] = 8'h01;
        dut_byp.ram.ram[1] = 8'h2A;
        b_re = 1'b1; b_addr = 6'h01;
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("byp_bd_one_edge", 32'(b_bd), 32'd1);
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("byp_read1", 32'(b_rd), 32'h2A);
        b_re = 1'b0; b_addr = 6'h00;
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("byp_hold", 32'(b_rd), 32'h2A);
        b_rst = 1'b1;
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("byp_rst_bd", 32'(b_bd), 32'd0);
        check("byp_rst_rd", 32'(b_rd), 32'd0);
        b_rst = 1'b0; b_re = 1'b1; b_addr = 6'h00;
        step(1'b0, 1'b0, 6'd0, 8'h00);
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("byp_survive0", 32'(b_rd), 32'h01);
        b_re = 1'b0;

        // Boot from reset, with a dropped write during boot.
        rst = 1'b0;
        cnt = 0;
        while (!bd && cnt < 200) begin
            if (cnt == 5) step(1'b1, 1'b0, 6'd3, 8'h55);
            else          step(1'b0, 1'(cnt % 3 == 0), 6'(cnt), 8'h00);
            cnt++;
        end
        check("boot_edges", 32'(cnt), 32'd64);
        step(1'b0, 1'b0, 6'd0, 8'h00);
        step(1'b0, 1'b1, 6'd3, 8'h00);
        step(1'b0, 1'b1, 6'd17, 8'h00);
        step(1'b0, 1'b0, 6'd0, 8'h00);

        // Write then read, then hold.
        step(1'b1, 1'b0, 6'h3F, 8'hA5);
        step(1'b0, 1'b1, 6'h3F, 8'h00);
        step(1'b0, 1'b0, 6'h00, 8'h00);
        step(1'b0, 1'b0, 6'h00, 8'h00);
        check("hold_a5", 32'(rd), 32'hA5);

        // Same-edge read and write: read-first.
        step(1'b1, 1'b0, 6'd5, 8'h11);
        step(1'b1, 1'b1, 6'd5, 8'h22);
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("rw_same_old", 32'(rd), 32'h11);
        step(1'b0, 1'b1, 6'd5, 8'h00);
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("rw_same_new", 32'(rd), 32'h22);

        // Reset while ready, then reset mid-boot at pointer 20.
        rst = 1'b1;
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("rst_ready_bd", 32'(bd), 32'd0);
        check("rst_ready_rd", 32'(rd), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 6'd0, 8'h00);
        check("midboot_bd", 32'(bd), 32'd0);
        rst = 1'b1;
        step(1'b0, 1'b0, 6'd0, 8'h00);
        rst = 1'b0;
        cnt = 0;
        while (!bd && cnt < 200) begin
            step(1'b1, 1'b1, 6'(cnt), 8'hFF);
            cnt++;
        end
        check("reboot_edges", 32'(cnt), 32'd64);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        end
        step(1'b0, 1'b0, 6'd0, 8'h00);
        step(1'b0, 1'b0, 6'd0, 8'h00);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
